// File: rtl/gearbox_din_dout_param_if.sv
// rtl/gearbox_din_dout_param_if.sv - word stream bundle between RX word source and gearbox
interface gearbox_din_dout_param_if #(
    parameter int DIN_WIDTH  = 20,
    parameter int DOUT_WIDTH = 67,
    parameter int CNT_WIDTH  = 7
);
    logic [DIN_WIDTH-1:0]  din;
    logic                  din_valid;
    logic                  slip;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [CNT_WIDTH-1:0]  fill;

    modport master (
        output din,
        output din_valid,
        output slip,
        input  dout,
        input  dout_valid,
        input  fill
    );

    modport slave (
        input  din,
        input  din_valid,
        input  slip,
        output dout,
        output dout_valid,
        output fill
    );
endinterface

// File: rtl/gearbox_din_dout_param.sv
// rtl/gearbox_din_dout_param.sv - narrow-to-wide gearbox, optional bit-slip under GEARBOX_SLIP_EN
module gearbox_din_dout_param #(
    parameter int DIN_WIDTH  = 20,
    parameter int DOUT_WIDTH = 67,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                     clk,
    input  logic                     arst,
    gearbox_din_dout_param_if.slave  bus
);
    // Residue buffer is left-justified: bit BUF_W-1 is the oldest bit, unused low bits are zero.
    localparam int BUF_W = DIN_WIDTH + DOUT_WIDTH - 1;

    logic [BUF_W-1:0]      buf_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;

    logic [BUF_W-1:0]      word_top;
    logic [BUF_W-1:0]      slot;
    logic [BUF_W-1:0]      merged;
    logic [CNT_WIDTH-1:0]  n;

`ifndef GEARBOX_SLIP_EN
    // Slip is ignored in this build; the name keeps the port visibly unused.
    logic slip_unused;
    assign slip_unused = bus.slip;
`endif

    // Place the incoming bits directly behind the residue and compute the new bit count.
    always_comb begin
        word_top = '0;
        n        = count_q + CNT_WIDTH'(DIN_WIDTH);
`ifdef GEARBOX_SLIP_EN
        if (bus.slip) begin
            // Earliest bit of the word is dropped, pushing block alignment one bit later.
            word_top[BUF_W-1 -: DIN_WIDTH-1] = bus.din[DIN_WIDTH-2:0];
            n = count_q + CNT_WIDTH'(DIN_WIDTH - 1);
        end else begin
            word_top[BUF_W-1 -: DIN_WIDTH] = bus.din;
        end
`else
        word_top[BUF_W-1 -: DIN_WIDTH] = bus.din;
`endif
        slot   = word_top >> count_q;
        merged = buf_q | slot;
    end

    // Consume a valid word and emit the oldest DOUT_WIDTH bits once a full block is present.
    always_ff @(posedge clk) begin
        if (arst) begin
            buf_q        <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            if (bus.din_valid) begin
                if (n >= CNT_WIDTH'(DOUT_WIDTH)) begin
                    dout_q       <= merged[BUF_W-1 -: DOUT_WIDTH];
                    dout_valid_q <= 1'b1;
                    buf_q        <= merged << DOUT_WIDTH;
                    count_q      <= n - CNT_WIDTH'(DOUT_WIDTH);
                end else begin
                    buf_q   <= merged;
                    count_q <= n;
                end
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.fill       = count_q;
endmodule

// File: tb/tb_gearbox_din_dout_param.sv
// tb/tb_gearbox_din_dout_param.sv - directed bench for gearbox_din_dout_param (20->67 and 8->33)
module tb_gearbox_din_dout_param;
    localparam int DW  = 20;
    localparam int OW  = 67;
    localparam int CW  = 7;
    localparam int DW2 = 8;
    localparam int OW2 = 33;
    localparam int CW2 = 6;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    gearbox_din_dout_param_if #(.DIN_WIDTH(DW),  .DOUT_WIDTH(OW),  .CNT_WIDTH(CW))  bus ();
    gearbox_din_dout_param_if #(.DIN_WIDTH(DW2), .DOUT_WIDTH(OW2), .CNT_WIDTH(CW2)) bus2 ();

    gearbox_din_dout_param #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    gearbox_din_dout_param #(.DIN_WIDTH(DW2), .DOUT_WIDTH(OW2), .CNT_WIDTH(CW2)) dut2 (
        .clk  (clk),
        .arst (arst),
        .bus  (bus2)
    );

    int checks   = 0;
    int failures = 0;

    logic [OW-1:0] blk [4];
    int            strobe_at [4];
    int            fill_exp  [4];
    bit            sq[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_blocks(input int nblk);
        sq.delete();
        for (int b = 0; b < nblk; b++)
            for (int i = OW - 1; i >= 0; i--)
                sq.push_back(blk[b][i]);
    endtask

    function automatic logic [DW-1:0] next_word();
        logic [DW-1:0] w;
        for (int i = DW - 1; i >= 0; i--)
            w[i] = (sq.size() > 0) ? sq.pop_front() : 1'b0;
        return w;
    endfunction

    task automatic step(input logic [DW-1:0] w, input logic v, input logic s);
        bus.din       = w;
        bus.din_valid = v;
        bus.slip      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        step('0, 1'b0, 1'b0);
        arst = 1'b0;
    endtask

    // Feed 4 blocks as 14 words; optional idle cycle after each word and optional slip on every word.
    task automatic run_stream(input string tag, input bit alt, input bit slip_all);
        int k;
        int fill_now;
        do_reset();
        load_blocks(4);
        k = 0;
        fill_now = 0;
        for (int i = 1; i <= 14; i++) begin
            step(next_word(), 1'b1, slip_all);
            if (k < 4 && i == strobe_at[k]) begin
                check({tag, "_valid"}, 128'(bus.dout_valid), 128'(1));
                check({tag, "_dout"}, 128'(bus.dout), 128'(blk[k]));
                check({tag, "_fill"}, 128'(bus.fill), 128'(fill_exp[k]));
                fill_now = fill_exp[k];
                k++;
            end else begin
                check({tag, "_novalid"}, 128'(bus.dout_valid), 128'(0));
                fill_now = fill_now + DW;
            end
            if (alt) begin
                step(20'hABCDE, 1'b0, 1'b1);
                check({tag, "_idle_valid"}, 128'(bus.dout_valid), 128'(0));
                check({tag, "_idle_fill"}, 128'(bus.fill), 128'(fill_now));
                if (k > 0) check({tag, "_idle_hold"}, 128'(bus.dout), 128'(blk[k-1]));
            end
        end
    endtask

    initial begin
        blk[0] = 67'h2_0123456789abcdef;
        blk[1] = 67'h2_fedcba9876543210;
        blk[2] = 67'h2_a5a5a5a55a5a5a5a;
        blk[3] = 67'h2_0f1e2d3c4b5a6978;
        strobe_at = '{4, 7, 11, 14};
        fill_exp  = '{13, 6, 19, 12};

        bus.din = '0; bus.din_valid = 1'b0; bus.slip = 1'b0;
        bus2.din = '0; bus2.din_valid = 1'b0; bus2.slip = 1'b0;
        arst = 1'b1;
        step('0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        check("rst_dout", 128'(bus.dout), 128'(0));
        check("rst_valid", 128'(bus.dout_valid), 128'(0));
        check("rst_fill", 128'(bus.fill), 128'(0));
        arst = 1'b0;

        // Single block packed into 4 words.
        load_blocks(1);
        step(next_word(), 1'b1, 1'b0);
        check("t1_w1_valid", 128'(bus.dout_valid), 128'(0));
        check("t1_w1_fill", 128'(bus.fill), 128'(20));
        step(next_word(), 1'b1, 1'b0);
        check("t1_w2_fill", 128'(bus.fill), 128'(40));
        step(next_word(), 1'b1, 1'b0);
        check("t1_w3_valid", 128'(bus.dout_valid), 128'(0));
        check("t1_w3_fill", 128'(bus.fill), 128'(60));
        step(next_word(), 1'b1, 1'b0);
        check("t1_w4_valid", 128'(bus.dout_valid), 128'(1));
        check("t1_w4_dout", 128'(bus.dout), 128'(67'h2_0123456789abcdef));
        check("t1_w4_fill", 128'(bus.fill), 128'(13));
        step('0, 1'b0, 1'b0);
        check("t1_strobe_once", 128'(bus.dout_valid), 128'(0));

        run_stream("t2", 1'b0, 1'b0);
        run_stream("t3", 1'b1, 1'b0);

`ifdef GEARBOX_SLIP_EN
        // Slip on the first word: first block appears one bit later in the stream.
        begin
            logic [OW-1:0] exp_shift;
            bit got_strobe;
            exp_shift = {blk[0][OW-2:0], blk[1][OW-1]};
            do_reset();
            load_blocks(4);
            step(next_word(), 1'b1, 1'b1);
            got_strobe = 1'b0;
            for (int i = 0; i < 8 && !got_strobe; i++) begin
                step(next_word(), 1'b1, 1'b0);
                if (bus.dout_valid) begin
                    got_strobe = 1'b1;
                    check("t4_slip_dout", 128'(bus.dout), 128'(exp_shift));
                    check("t4_slip_fill", 128'(bus.fill), 128'(12));
                end
            end
            check("t4_slip_strobe_seen", 128'(got_strobe), 128'(1));
        end
`else
        run_stream("t4_noslip", 1'b0, 1'b1);
`endif

        // Reset mid-block discards partial data.
        do_reset();
        load_blocks(1);
        step(next_word(), 1'b1, 1'b0);
        step(next_word(), 1'b1, 1'b0);
        arst = 1'b1;
        step(20'hFFFFF, 1'b1, 1'b0);
        arst = 1'b0;
        check("t5_rst_valid", 128'(bus.dout_valid), 128'(0));
        check("t5_rst_fill", 128'(bus.fill), 128'(0));
        check("t5_rst_dout", 128'(bus.dout), 128'(0));
        load_blocks(1);
        for (int i = 1; i <= 4; i++) begin
            step(next_word(), 1'b1, 1'b0);
            check("t5_valid", 128'(bus.dout_valid), 128'(i == 4));
        end
        check("t5_dout", 128'(bus.dout), 128'(blk[0]));
        check("t5_fill", 128'(bus.fill), 128'(13));

        // 8->33 instance with random data and random valid against a bit queue.
        begin
            bit rq[$];
            logic [OW2-1:0] e;
            logic [DW2-1:0] w;
            logic v;
            do_reset();
            for (int i = 0; i < 120; i++) begin
                w = DW2'($urandom);
                v = ($urandom_range(0, 3) != 0);
                bus2.din = w;
                bus2.din_valid = v;
                bus2.slip = 1'b0;
                @(posedge clk);
                #1;
                if (v)
                    for (int b = DW2 - 1; b >= 0; b--) rq.push_back(w[b]);
                if (rq.size() >= OW2) begin
                    for (int b = OW2 - 1; b >= 0; b--) e[b] = rq.pop_front();
                    check("t6_valid", 128'(bus2.dout_valid), 128'(1));
                    check("t6_dout", 128'(bus2.dout), 128'(e));
                end else begin
                    check("t6_novalid", 128'(bus2.dout_valid), 128'(0));
                end
                check("t6_fill", 128'(bus2.fill), 128'(rq.size()));
            end
            bus2.din_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
